// File: rtl/dds_pkg.sv
// Shared encodings for the DDS sweep sequencer: sweep modes, DDS wave selects
// and the sequencer state.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_REPEAT   = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SAW      = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/dds_sweep_step.sv
// Next frequency word for the sweep: one step towards the leg's end word,
// saturated at that end, with an optional bounce towards the opposite end.
module dds_sweep_step #(
    parameter int FW_W = 32
) (
    input  logic [FW_W-1:0] cur,
    input  logic [FW_W-1:0] step,
    input  logic [FW_W-1:0] tgt,
    input  logic [FW_W-1:0] away,
    input  logic            dir_up,
    input  logic            bounce,
    output logic [FW_W-1:0] nxt,
    output logic            at_end
);

    // One extra bit lets overflow past the top and underflow past zero clamp
    // to the limit instead of wrapping.
    function automatic logic [FW_W-1:0] step_sat(
        input logic [FW_W-1:0] c,
        input logic [FW_W-1:0] s,
        input logic [FW_W-1:0] lim,
        input logic            up
    );
        logic [FW_W:0] acc;
        if (up) begin
            acc      = {1'b0, c} + {1'b0, s};
            step_sat = (acc >= {1'b0, lim}) ? lim : acc[FW_W-1:0];
        end else begin
            acc      = {1'b0, c} - {1'b0, s};
            step_sat = (acc[FW_W] || (acc <= {1'b0, lim})) ? lim : acc[FW_W-1:0];
        end
    endfunction

    always_comb begin
        at_end = (cur == tgt);
        nxt    = step_sat(cur, step, tgt, dir_up);
        if (at_end) begin
            nxt = bounce ? step_sat(cur, step, away, ~dir_up) : cur;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS configuration: captures a sweep
// descriptor on start and steps f_word between two endpoints with a dwell.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_W = 32,
    parameter int PW_W = 12,
    parameter int DW_W = 24
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            abort,
    input  logic [FW_W-1:0] cfg_start_f,
    input  logic [FW_W-1:0] cfg_stop_f,
    input  logic [FW_W-1:0] cfg_step_f,
    input  logic [DW_W-1:0] cfg_dwell,
    input  logic [1:0]      cfg_mode,
    input  logic [1:0]      cfg_wave,
    input  logic [PW_W-1:0] cfg_p_word,
    output logic            dds_en,
    output logic [FW_W-1:0] f_word,
    output logic [PW_W-1:0] p_word,
    output logic [1:0]      wave_type,
    output logic            busy,
    output logic            done,
    output logic            upd,
    output logic            cfg_err
);

    state_t          state;
    logic [DW_W-1:0] cnt;
    logic            leg_out;

    logic [FW_W-1:0] sh_start_f;
    logic [FW_W-1:0] sh_stop_f;
    logic [FW_W-1:0] sh_step_f;
    logic [DW_W-1:0] sh_dwell;
    mode_t           sh_mode;
    logic            sh_up;

    logic            cfg_ok;
    logic            accept;
    logic [DW_W-1:0] dwell_last;
    logic [FW_W-1:0] tgt;
    logic [FW_W-1:0] away;
    logic            dir_up;
    logic            bounce;
    logic [FW_W-1:0] nxt;
    logic            at_end;

    assign cfg_ok     = (cfg_step_f != '0) && (cfg_mode != MODE_RSVD);
    assign accept     = start && !abort && (state != ST_RUN) && cfg_ok;
    assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - {{(DW_W-1){1'b0}}, 1'b1};

    // leg_out=1 moves start->stop; a ping-pong return leg runs the other way.
    assign tgt    = leg_out ? sh_stop_f  : sh_start_f;
    assign away   = leg_out ? sh_start_f : sh_stop_f;
    assign dir_up = leg_out ? sh_up : ~sh_up;
    assign bounce = (sh_mode == MODE_PINGPONG);

    dds_sweep_step #(
        .FW_W(FW_W)
    ) u_step (
        .cur   (f_word),
        .step  (sh_step_f),
        .tgt   (tgt),
        .away  (away),
        .dir_up(dir_up),
        .bounce(bounce),
        .nxt   (nxt),
        .at_end(at_end)
    );

    // Sweep descriptor, frozen for the duration of a sweep.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            sh_start_f <= cfg_start_f;
            sh_stop_f  <= cfg_stop_f;
            sh_step_f  <= cfg_step_f;
            sh_dwell   <= cfg_dwell;
            sh_mode    <= mode_t'(cfg_mode);
            sh_up      <= (cfg_stop_f >= cfg_start_f);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            leg_out   <= 1'b1;
            dds_en    <= 1'b0;
            f_word    <= '0;
            p_word    <= '0;
            wave_type <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            upd       <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            upd     <= 1'b0;
            cfg_err <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                leg_out <= 1'b1;
                dds_en  <= 1'b0;
                f_word  <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_HOLD: begin
                        if (accept) begin
                            state     <= ST_RUN;
                            cnt       <= '0;
                            leg_out   <= 1'b1;
                            dds_en    <= 1'b1;
                            busy      <= 1'b1;
                            f_word    <= cfg_start_f;
                            upd       <= 1'b1;
                            p_word    <= cfg_p_word;
                            wave_type <= cfg_wave;
                        end else if (start) begin
                            cfg_err <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (cnt == dwell_last) begin
                            cnt <= '0;
                            if (!at_end) begin
                                f_word <= nxt;
                                upd    <= 1'b1;
                            end else begin
                                case (sh_mode)
                                    MODE_ONESHOT: begin
                                        state <= ST_HOLD;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                    MODE_REPEAT: begin
                                        f_word <= sh_start_f;
                                        upd    <= (f_word != sh_start_f);
                                    end
                                    default: begin
                                        f_word  <= nxt;
                                        upd     <= (nxt != f_word);
                                        leg_out <= ~leg_out;
                                    end
                                endcase
                            end
                        end else begin
                            cnt <= cnt + {{(DW_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
